multi_key_ctrl: RTL
===================

// Module: multi_key_ctrl
// PURPOSE
//  Parametrised N-key front end: per-key sync + debounce + press/long-press detection
//  and per-key output level (toggle or follow). Sits between board push-buttons and
//  control logic (e.g. DDR3 read/write enables, mode selects); one instance serves all keys.
// PARAMETERS
//  FREQ        28'd25_000_000  input clock frequency, Hz (CYC_MS = FREQ/1000 cycles per ms)
//  KEY_NUM     4               number of keys, >=1
//  KEY_ACT     1'b0            key_in level meaning "pressed" (0 = active-low buttons)
//  DEB_MS      20              debounce time, ms; DEB_CNT = CYC_MS*DEB_MS, >=1
//  LONG_MS     1000            long-press threshold, ms; LONG_CNT = CYC_MS*LONG_MS, > DEB_CNT
//  TOGGLE_MASK {KEY_NUM{1'b1}} bit i=1: state_out[i] toggles on press; 0: follows key_level[i]
//  LONG_CLR    1'b1            1: long press forces state_out[i]=0 on toggle keys
// PORTS
//  clk        in   1        system clock
//  rst        in   1        asynchronous reset, active-high
//  key_in     in   KEY_NUM  raw asynchronous button levels
//  key_level  out  KEY_NUM  debounced level, 1 = pressed
//  key_press  out  KEY_NUM  1-cycle pulse on accepted press
//  key_long   out  KEY_NUM  1-cycle pulse when hold reaches LONG_CNT (once per press)
//  state_out  out  KEY_NUM  toggle/follow level per TOGGLE_MASK
// BEHAVIOUR
//  - rst asserted (any time, incl. mid-debounce/mid-hold): every key FSM -> IDLE, all
//    counters 0, sync flops to released level, all outputs 0 immediately.
//  - Per key: 2-flop synchroniser; s = (sync_out == KEY_ACT). Keys fully independent.
//  - deb_cnt: $clog2(DEB_CNT+1) bits; hold_cnt: $clog2(LONG_CNT+1) bits, saturating.
//  - FSM per key:
//    IDLE:     s=1 -> PRESS_DB, deb_cnt=1.
//    PRESS_DB: s=0 -> IDLE, deb_cnt=0 (bounce rejected).
//              s=1 & deb_cnt==DEB_CNT -> HELD; next cycle key_press=1, key_level=1,
//              hold_cnt=0. else deb_cnt++.
//    HELD:     hold_cnt++ each cycle; when it becomes LONG_CNT (first time only):
//              key_long=1 for 1 cycle -> LONG. s=0 -> REL_DB, deb_cnt=1.
//    LONG:     hold_cnt frozen; s=0 -> REL_DB, deb_cnt=1.
//    REL_DB:   hold_cnt keeps counting (if not yet LONG); s=1 -> back to prior state
//              (HELD/LONG), deb_cnt=0, no new press pulse.
//              s=0 & deb_cnt==DEB_CNT -> IDLE, key_level=0 next cycle. else deb_cnt++.
//      key_long may fire while in REL_DB if hold_cnt hits LONG_CNT there.
//  - Latency: clean edge at key_in in cycle 0 -> key_press high in cycle 2+DEB_CNT+1
//    (2 sync + DEB_CNT samples + 1 registered output). Release: key_level low same offset.
//  - state_out[i], TOGGLE_MASK[i]=1: inverts on key_press[i]; on key_long[i] with
//    LONG_CLR=1 forced 0 (overrides; press and long never coincide since LONG_CNT>DEB_CNT).
//    TOGGLE_MASK[i]=0: state_out[i] = key_level[i] (registered copy, same cycle).
//  - Simultaneous presses on several keys: each key pulses independently, same cycle allowed.
//  - Key held indefinitely: exactly one key_press and at most one key_long; no repeat.
//  - All outputs registered; no combinational path key_in -> outputs.
// TESTING  (bench params: FREQ=1000 -> CYC_MS=1, DEB_MS=4, LONG_MS=20, KEY_NUM=4,
//           KEY_ACT=0, TOGGLE_MASK=4'b0111, LONG_CLR=1)
//  1 key_in[0] 1->0 held 10 cyc -> key_press[0] 1 cyc at cycle 7; key_level[0]=1;
//    state_out[0] 0->1; released -> key_level[0]=0 7 cyc after release; no key_long.
//  2 key_in[1] glitch low 3 cyc, 5x -> no key_press, key_level/state_out stay 0.
//  3 key_in[2] held 40 cyc after state_out[2]=1 -> key_press toggles to 0->1? no: press
//    toggles 1->0, key_long at press+20 cycles forces 0; exactly 1 press + 1 long pulse.
//  4 key_in[3] (follow mode) press 8 cyc then release -> state_out[3] mirrors key_level[3].
//  5 keys 0 and 1 pressed same cycle -> both key_press pulses in same cycle; 1-cyc release
//    bounce mid-hold -> no second press pulse.
//  6 rst pulsed mid-hold (HELD, state_out=1) -> all outputs 0 at once; key still low after
//    rst release -> fresh press detected 7 cyc later, state_out -> 1.

Source files
------------

// File: rtl/multi_key_ctrl.sv
// N-key push-button front end: sync, debounce, press / long-press pulses
// and a per-key toggle or follow output level.
module multi_key_ctrl #(
  parameter logic [27:0]        FREQ        = 28'd25_000_000,
  parameter int                 KEY_NUM     = 4,
  parameter logic               KEY_ACT     = 1'b0,
  parameter int                 DEB_MS      = 20,
  parameter int                 LONG_MS     = 1000,
  parameter logic [KEY_NUM-1:0] TOGGLE_MASK = {KEY_NUM{1'b1}},
  parameter logic               LONG_CLR    = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_level,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_long,
  output logic [KEY_NUM-1:0] state_out
);

  localparam int CYC_MS   = int'(FREQ) / 1000;
  localparam int DEB_CNT  = CYC_MS * DEB_MS;
  localparam int LONG_CNT = CYC_MS * LONG_MS;
  localparam int DW       = $clog2(DEB_CNT + 1);
  localparam int HW       = $clog2(LONG_CNT + 1);

  localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CNT);
  localparam logic [DW-1:0] DEB_ONE  = DW'(1);
  localparam logic [HW-1:0] LONG_MAX = HW'(LONG_CNT);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    HELD,
    LONG,
    REL_DB
  } state_t;

  for (genvar i = 0; i < KEY_NUM; i++) begin : g_key
    logic [1:0]    sync;
    logic          s;
    state_t        st;
    logic [DW-1:0] deb;
    logic [HW-1:0] hold;
    logic          level;
    logic          press;
    logic          lng;
    logic          sout;
    logic          counting;
    logic          long_hit;

    assign s        = (sync[1] == KEY_ACT);
    assign counting = (st == HELD || st == REL_DB)
                      && (hold != LONG_MAX);
    assign long_hit = counting && (hold + HOLD_ONE == LONG_MAX);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync  <= {2{~KEY_ACT}};
        st    <= IDLE;
        deb   <= '0;
        hold  <= '0;
        level <= 1'b0;
        press <= 1'b0;
        lng   <= 1'b0;
        sout  <= 1'b0;
      end else begin
        sync  <= {sync[0], key_in[i]};
        press <= 1'b0;
        lng   <= 1'b0;
        // hold time keeps running through release bounce
        if (counting) begin
          hold <= hold + HOLD_ONE;
          if (long_hit) begin
            lng <= 1'b1;
            if (TOGGLE_MASK[i] && LONG_CLR)
              sout <= 1'b0;
          end
        end
        unique case (st)
          IDLE: begin
            if (s) begin
              st  <= PRESS_DB;
              deb <= DEB_ONE;
            end
          end
          PRESS_DB: begin
            if (!s) begin
              st  <= IDLE;
              deb <= '0;
            end else if (deb == DEB_MAX) begin
              st    <= HELD;
              deb   <= '0;
              hold  <= '0;
              press <= 1'b1;
              level <= 1'b1;
              sout  <= TOGGLE_MASK[i] ? ~sout : 1'b1;
            end else begin
              deb <= deb + DEB_ONE;
            end
          end
          HELD: begin
            if (!s) begin
              st  <= REL_DB;
              deb <= DEB_ONE;
            end else if (long_hit) begin
              st <= LONG;
            end
          end
          LONG: begin
            if (!s) begin
              st  <= REL_DB;
              deb <= DEB_ONE;
            end
          end
          REL_DB: begin
            if (s) begin
              st  <= (hold == LONG_MAX || long_hit) ? LONG : HELD;
              deb <= '0;
            end else if (deb == DEB_MAX) begin
              st    <= IDLE;
              deb   <= '0;
              hold  <= '0;
              level <= 1'b0;
              if (!TOGGLE_MASK[i])
                sout <= 1'b0;
            end else begin
              deb <= deb + DEB_ONE;
            end
          end
          default: begin
            st  <= IDLE;
            deb <= '0;
          end
        endcase
      end
    end

    assign key_level[i] = level;
    assign key_press[i] = press;
    assign key_long[i]  = lng;
    assign state_out[i] = sout;
  end

endmodule
